// File: rtl/rtc_key_scheduler_if.sv
// Handshake/status bundle between the RTC key scheduler and its controller/key store.
interface rtc_key_scheduler_if #(
  parameter int KEY_IDX_W = 2
);
  logic                 start;
  logic                 stop;
  logic                 key_ack;
  logic                 scan_tick;
  logic                 sec_tick;
  logic                 key_req;
  logic [KEY_IDX_W-1:0] key_idx;
  logic                 running;
  logic                 missed;

  modport master (
    output start, stop, key_ack,
    input  scan_tick, sec_tick, key_req, key_idx, running, missed
  );

  modport slave (
    input  start, stop, key_ack,
    output scan_tick, sec_tick, key_req, key_idx, running, missed
  );
endinterface

// File: rtl/rtc_key_scheduler.sv
// Enable-strobe tick generator and key-rotation sequencer for the RTC lock datapath.
// All outputs are registered; scan/sec strobes replace divided clocks in the sys_clk domain.
module rtc_key_scheduler #(
  parameter int CLK_HZ           = 1000000,
  parameter int SCAN_HZ          = 500,
  parameter int KEYCHANGE_PERIOD = 5,
  parameter int NUM_KEYS         = 4,
  parameter int KEY_IDX_W        = 2
) (
  input logic                sys_clk,
  input logic                rst_n,
  rtc_key_scheduler_if.slave bus
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SEC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int PER_W    = (KEYCHANGE_PERIOD > 1) ? $clog2(KEYCHANGE_PERIOD) : 1;

  localparam logic [SCAN_W-1:0]    SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SEC_W-1:0]     SEC_MAX  = SEC_W'(CLK_HZ - 1);
  localparam logic [PER_W-1:0]     PER_MAX  = PER_W'(KEYCHANGE_PERIOD - 1);
  localparam logic [KEY_IDX_W-1:0] KEY_MAX  = KEY_IDX_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REQ} state_t;

  state_t               state_q, state_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [SEC_W-1:0]     sec_cnt_q, sec_cnt_d;
  logic [PER_W-1:0]     per_cnt_q, per_cnt_d;
  logic                 scan_tick_q, scan_tick_d;
  logic                 sec_tick_q, sec_tick_d;
  logic                 key_req_q, key_req_d;
  logic [KEY_IDX_W-1:0] key_idx_q, key_idx_d;
  logic                 running_q, running_d;
  logic                 missed_q, missed_d;

  logic scan_wrap, sec_wrap, expiry;

  function automatic logic [KEY_IDX_W-1:0] next_idx(input logic [KEY_IDX_W-1:0] idx);
    next_idx = (idx == KEY_MAX) ? '0 : idx + 1'b1;
  endfunction

  assign scan_wrap = (scan_cnt_q == SCAN_MAX);
  assign sec_wrap  = (sec_cnt_q == SEC_MAX);
  // Expiry is the cycle in which the period counter wraps on a second boundary.
  assign expiry    = sec_wrap && (per_cnt_q == PER_MAX);

  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    per_cnt_d   = per_cnt_q;
    scan_tick_d = 1'b0;
    sec_tick_d  = 1'b0;
    key_req_d   = key_req_q;
    key_idx_d   = key_idx_q;
    running_d   = running_q;
    missed_d    = missed_q;

    if (state_q == S_IDLE) begin
      scan_cnt_d = '0;
      sec_cnt_d  = '0;
      per_cnt_d  = '0;
      if (start_i() && !bus.stop) begin
        state_d   = S_RUN;
        running_d = 1'b1;
        missed_d  = 1'b0;
      end
    end else if (bus.stop) begin
      // key_idx and missed survive a stop; they only clear on the next start or reset.
      state_d    = S_IDLE;
      scan_cnt_d = '0;
      sec_cnt_d  = '0;
      per_cnt_d  = '0;
      key_req_d  = 1'b0;
      running_d  = 1'b0;
    end else begin
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      sec_cnt_d   = sec_wrap ? '0 : sec_cnt_q + 1'b1;
      if (sec_wrap) begin
        per_cnt_d = (per_cnt_q == PER_MAX) ? '0 : per_cnt_q + 1'b1;
      end
      scan_tick_d = scan_wrap;
      sec_tick_d  = sec_wrap;

      case (state_q)
        S_RUN: begin
          if (expiry) begin
            key_idx_d = next_idx(key_idx_q);
            key_req_d = 1'b1;
            state_d   = S_REQ;
          end
        end
        S_REQ: begin
          // An ack landing on an expiry is consumed and re-requests with no low gap.
          if (bus.key_ack) begin
            if (expiry) begin
              key_idx_d = next_idx(key_idx_q);
            end else begin
              key_req_d = 1'b0;
              state_d   = S_RUN;
            end
          end else if (expiry) begin
            missed_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  function automatic logic start_i();
    start_i = bus.start;
  endfunction

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      scan_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      per_cnt_q   <= '0;
      scan_tick_q <= 1'b0;
      sec_tick_q  <= 1'b0;
      key_req_q   <= 1'b0;
      key_idx_q   <= '0;
      running_q   <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      per_cnt_q   <= per_cnt_d;
      scan_tick_q <= scan_tick_d;
      sec_tick_q  <= sec_tick_d;
      key_req_q   <= key_req_d;
      key_idx_q   <= key_idx_d;
      running_q   <= running_d;
      missed_q    <= missed_d;
    end
  end

  assign bus.scan_tick = scan_tick_q;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.key_req   = key_req_q;
  assign bus.key_idx   = key_idx_q;
  assign bus.running   = running_q;
  assign bus.missed    = missed_q;

endmodule

// File: tb/tb_rtc_key_scheduler.sv
// Scoreboard bench for rtc_key_scheduler: expected strobes and key_req edges are queued by
// the stimulus thread and popped by a negedge monitor; level checks are made inline.
module tb_rtc_key_scheduler;

  localparam int CLK_HZ = 100;
  localparam int SCAN_HZ = 10;
  localparam int KCP = 2;
  localparam int NK = 3;
  localparam int KW = 2;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

  typedef struct {
    int cyc;
    bit sec;
  } tick_ev_t;

  typedef struct {
    int       cyc;
    bit       rise;
    int       idx;
    bit       missed;
  } req_ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   base;
  bit   req_prev;

  tick_ev_t tick_q[$];
  req_ev_t  req_q[$];

  rtc_key_scheduler_if #(.KEY_IDX_W(KW)) bus ();

  rtc_key_scheduler #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .KEYCHANGE_PERIOD(KCP),
    .NUM_KEYS(NK), .KEY_IDX_W(KW)
  ) dut (
    .sys_clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_ticks(input int b, input int last);
    for (int t = SCAN_DIV; t <= last; t += SCAN_DIV) begin
      tick_q.push_back('{cyc: b + t, sec: 1'b0});
      if (t % CLK_HZ == 0) tick_q.push_back('{cyc: b + t, sec: 1'b1});
    end
  endtask

  task automatic push_req(input int c, input bit rise, input int idx, input bit m);
    req_q.push_back('{cyc: c, rise: rise, idx: idx, missed: m});
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    base = cyc + 1;
    step();
    bus.start = 1'b0;
    chk("running_after_start", int'(bus.running), 1);
  endtask

  task automatic do_stop(input int at);
    wait_until(at);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("running_after_stop", int'(bus.running), 0);
    chk("key_req_after_stop", int'(bus.key_req), 0);
  endtask

  task automatic pulse_ack(input int at);
    wait_until(at);
    bus.key_ack = 1'b1;
    step();
    bus.key_ack = 1'b0;
  endtask

  task automatic chk_tick(input bit sec);
    tick_ev_t e;
    n_tests++;
    if (tick_q.size() == 0) begin
      n_fail++;
      $display("FAIL tick_unexpected: sec=%0d at cycle %0d, none expected", sec, cyc);
    end else begin
      e = tick_q.pop_front();
      if (e.cyc != cyc || e.sec != sec) begin
        n_fail++;
        $display("FAIL tick: got sec=%0d at cycle %0d, expected sec=%0d at cycle %0d",
                 sec, cyc, e.sec, e.cyc);
      end
    end
  endtask

  task automatic chk_req_edge(input bit rise);
    req_ev_t e;
    n_tests++;
    if (req_q.size() == 0) begin
      n_fail++;
      $display("FAIL key_req_unexpected: rise=%0d at cycle %0d, none expected", rise, cyc);
    end else begin
      e = req_q.pop_front();
      if (e.cyc != cyc || e.rise != rise || e.idx != int'(bus.key_idx) ||
          e.missed != bus.missed) begin
        n_fail++;
        $display("FAIL key_req_edge: got rise=%0d cyc=%0d idx=%0d missed=%0d, expected rise=%0d cyc=%0d idx=%0d missed=%0d",
                 rise, cyc, bus.key_idx, bus.missed, e.rise, e.cyc, e.idx, e.missed);
      end
    end
  endtask

  initial begin
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.scan_tick) chk_tick(1'b0);
      if (bus.sec_tick) chk_tick(1'b1);
      if (bus.key_req != req_prev) chk_req_edge(bus.key_req);
      req_prev = bus.key_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.key_ack = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_running", int'(bus.running), 0);
    chk("rst_key_req", int'(bus.key_req), 0);
    chk("rst_key_idx", int'(bus.key_idx), 0);
    chk("rst_missed", int'(bus.missed), 0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_running", int'(bus.running), 0);

    // Normal rotation with acks; wraps 2 -> 0 at the third request.
    do_start();
    push_ticks(base, 600);
    push_req(base + 200, 1, 1, 0);
    push_req(base + 206, 0, 1, 0);
    push_req(base + 400, 1, 2, 0);
    push_req(base + 406, 0, 2, 0);
    push_req(base + 600, 1, 0, 0);
    push_req(base + 604, 0, 0, 0);
    wait_until(base + 200);
    chk("first_req_idx", int'(bus.key_idx), 1);
    pulse_ack(base + 205);
    chk("req_fall_after_ack", int'(bus.key_req), 0);
    pulse_ack(base + 405);
    pulse_ack(base + 603);
    do_stop(base + 607);
    chk("idx_retained_a", int'(bus.key_idx), 0);

    // Missed period: no ack until after the second expiry.
    do_start();
    push_ticks(base, 450);
    push_req(base + 200, 1, 1, 0);
    push_req(base + 411, 0, 1, 1);
    wait_until(base + 400);
    chk("missed_set", int'(bus.missed), 1);
    chk("missed_idx_held", int'(bus.key_idx), 1);
    chk("missed_req_high", int'(bus.key_req), 1);
    pulse_ack(base + 410);
    wait_until(base + 412);
    chk("missed_sticky", int'(bus.missed), 1);
    do_stop(base + 450);
    chk("idx_retained_b", int'(bus.key_idx), 1);
    chk("missed_retained", int'(bus.missed), 1);

    // start and stop together in IDLE stays idle.
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step();
    step();
    chk("start_stop_idle", int'(bus.running), 0);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    step();

    // Ack coinciding with expiry, then stop in REQ.
    do_start();
    chk("start_clears_missed", int'(bus.missed), 0);
    push_ticks(base, 400);
    push_req(base + 200, 1, 2, 0);
    push_req(base + 406, 0, 0, 0);
    pulse_ack(base + 399);
    chk("same_cycle_req_high", int'(bus.key_req), 1);
    chk("same_cycle_idx", int'(bus.key_idx), 0);
    chk("same_cycle_missed", int'(bus.missed), 0);
    do_stop(base + 405);
    chk("idx_retained_c", int'(bus.key_idx), 0);

    // Asynchronous reset in REQ.
    do_start();
    push_ticks(base, 200);
    push_req(base + 200, 1, 1, 0);
    push_req(base + 203, 0, 0, 0);
    wait_until(base + 203);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_key_req", int'(bus.key_req), 0);
    chk("async_rst_key_idx", int'(bus.key_idx), 0);
    chk("async_rst_running", int'(bus.running), 0);
    step();
    step();
    #2 rst_n = 1'b1;
    repeat (300) step();
    chk("post_rst_running", int'(bus.running), 0);
    chk("post_rst_key_req", int'(bus.key_req), 0);
    chk("tick_queue_drained", tick_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_key_scheduler.md
# rtc_key_scheduler

Tick scheduler and key-rotation controller for the RTC lock datapath, running entirely in the `sys_clk` (1 MHz) domain. It replaces derived divided clocks with single-cycle enable strobes. It produces a display-scan strobe at SCAN_HZ and sequences key rotation every KEYCHANGE_PERIOD seconds. Each rotation is handed to the key store over a req/ack handshake, and overruns are flagged when the key store is slow.

## Interface
- CLK_HZ, 1000000, `sys_clk` frequency; must be divisible by SCAN_HZ.
- SCAN_HZ, 500, scan strobe rate; SCAN_DIV = CLK_HZ/SCAN_HZ (2000 at default).
- KEYCHANGE_PERIOD, 5, seconds between key changes; ≥1.
- NUM_KEYS, 4, number of keys in rotation; 2 ≤ NUM_KEYS ≤ 2^KEY_IDX_W.
- KEY_IDX_W, 2, width of key_idx.
- sys_clk  in  1  system clock, 1 MHz nominal.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- start  in  1  level-sampled; in IDLE, begins scheduling.
- stop  in  1  level-sampled; returns to IDLE from any state; priority over start.
- key_ack  in  1  key store accepted current key_idx.
- scan_tick  out  1  one-cycle strobe every SCAN_DIV cycles while running.
- sec_tick  out  1  one-cycle strobe every CLK_HZ cycles while running.
- key_req  out  1  key change pending; held until key_ack.
- key_idx  out  KEY_IDX_W  index of the active/requested key.
- running  out  1  high in RUN or REQ.
- missed  out  1  sticky: a period expired while a request was still pending.

## Operation
- States: IDLE, RUN, REQ. All outputs are registered.
- Reset values:
  - state is IDLE.
  - scan_tick, sec_tick, key_req, running and missed are 0.
  - key_idx is 0.
  - All counters are 0.
- IDLE:
  - Counters are held at 0 and no strobes are produced.
  - start=1 with stop=0 goes to RUN. Counters are cleared and missed is cleared.
  - key_idx is retained.
- Counters, active in RUN and REQ:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps. scan_tick=1 in the cycle after scan_cnt==SCAN_DIV-1.
  - sec_cnt counts 0..CLK_HZ-1 and wraps. sec_tick is produced the same way.
  - per_cnt counts sec_tick pulses 0..KEYCHANGE_PERIOD-1. The cycle in which the wrap occurs is the "expiry".
  - Counter widths are $clog2 of the modulus, minimum 1.
- RUN, on expiry:
  - key_idx advances to key_idx+1; NUM_KEYS-1 wraps to 0.
  - key_req is set and the state becomes REQ.
- REQ, counters keep running:
  - key_ack=1 with no expiry: key_req clears and the state returns to RUN.
  - Expiry with no key_ack: missed is set, key_idx does NOT advance, and key_req stays high.
  - key_ack and expiry in the same cycle: the ack is consumed, key_idx advances, and key_req stays high for the new request. There is no low gap and missed is not set.
- key_ack while key_req=0 is ignored.
- stop=1 in any state goes to IDLE next cycle:
  - key_req, running, scan_tick and sec_tick are 0.
  - Counters are cleared.
  - key_idx and missed are retained until the next start.
- rst_n low mid-operation asynchronously forces all reset values, including key_idx=0.

## Timing
- Start to running=1: 1 cycle.
- Define cycle 0 as the first cycle with running=1, where counters are at 0:
  - First scan_tick is at cycle SCAN_DIV, then every SCAN_DIV cycles.
  - First sec_tick is at cycle CLK_HZ.
  - First key_req rises at cycle KEYCHANGE_PERIOD·CLK_HZ, together with the updated key_idx.
- key_idx is stable for the whole time key_req=1.
- key_req falls in the cycle after key_ack is sampled high.
- Strobes are exactly 1 cycle wide. scan_tick and sec_tick coincide when CLK_HZ is a multiple of SCAN_DIV.
- There are no combinational paths from inputs to outputs.

## Test plan
Use bench parameters CLK_HZ=100, SCAN_HZ=10, KEYCHANGE_PERIOD=2, NUM_KEYS=3.
- Reset then start pulse: running=1 after 1 cycle. scan_tick at cycles 10,20,…; sec_tick at 100,200. key_req rises at cycle 200 with key_idx=1.
- Ack at cycle 205: key_req falls at 206. Next key_req at 400 with key_idx=2, then at 600 with key_idx=0 (wrap).
- Never ack after the first request: at cycle 400 missed=1, key_idx stays 1 and key_req stays high. An ack at 410 drops key_req at 411; missed remains 1.
- key_ack in the same cycle as the expiry at 400: key_idx goes 1→2 and key_req stays continuously high with missed=0.
- start and stop asserted together in IDLE: remains IDLE with running=0. stop in REQ: next cycle key_req=0 and running=0; key_idx is retained. A following start clears missed and gives the next key_req 200 cycles later.
- rst_n low mid-REQ (asynchronous, between clock edges): all outputs reset immediately and key_idx=0. After rst_n rises, there is no activity until start.
